instr_class_tracker: RTL and testbench

//  Pipelined successor to the combinational instruction classifier. Takes the func class

---
 rtl/instr_class_tracker.sv | 126 ++++++++++++
 tb/tb_instr_class_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_class_tracker.sv
// Carries the decoded func class through the post-Decode stages with bubbles and flush,
// exposes an in-flight class mask, and keeps saturating per-class retire counters.
module instr_class_tracker #(
  parameter  int FUNC_W    = 4,
  parameter  int NUM_CLASS = 9,
  parameter  int STAGES    = 3,
  parameter  int CNT_W     = 32,
  localparam int SEL_W     = $clog2(NUM_CLASS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [FUNC_W-1:0]        in_func,
  input  logic                     stall,
  input  logic                     flush,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*FUNC_W-1:0] stage_func,
  output logic [NUM_CLASS-1:0]     inflight,
  output logic                     retire,
  input  logic [SEL_W-1:0]         cnt_sel,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         cnt_value
);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [FUNC_W-1:0] fn_q [STAGES];
  logic [FUNC_W-1:0] fn_d [STAGES];
  logic [FUNC_W-1:0] in_cls;
  logic [FUNC_W-1:0] ret_fn;

  logic [CNT_W-1:0] cnt_q [NUM_CLASS];
  logic [CNT_W-1:0] cnt_d [NUM_CLASS];
  logic [CNT_W-1:0] rd_val;
  logic [CNT_W-1:0] cnt_value_q;

  // Out-of-range codes fold into OTHER
  assign in_cls = (32'(in_func) >= NUM_CLASS) ?
                  FUNC_W'(NUM_CLASS - 1) : in_func;

  always_comb begin
    vld_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      fn_d[k] = '0;
    end
    if (in_valid && !stall && !flush) begin
      vld_d[0] = 1'b1;
      fn_d[0]  = in_cls;
    end
    // The last stage keeps advancing on flush so its occupant still retires
    for (int k = 1; k < STAGES; k++) begin
      if (!flush || k == STAGES - 1) begin
        vld_d[k] = vld_q[k-1];
        fn_d[k]  = fn_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        fn_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < STAGES; k++) begin
        fn_q[k] <= fn_d[k];
      end
    end
  end

  always_comb begin
    stage_func = '0;
    inflight   = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_func[k*FUNC_W +: FUNC_W] = fn_q[k];
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (vld_q[k] && 32'(fn_q[k]) == c) begin
          inflight[c] = 1'b1;
        end
      end
    end
  end

  assign stage_valid = vld_q;
  assign retire      = vld_q[STAGES-1];
  assign ret_fn      = fn_q[STAGES-1];

  // Clear beats a same-cycle retire; counts stick at all-ones
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (cnt_clr) begin
        cnt_d[c] = '0;
      end else if (retire && 32'(ret_fn) == c && cnt_q[c] != '1) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (32'(cnt_sel) == c) begin
        rd_val = cnt_q[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_value_q <= '0;
      for (int c = 0; c < NUM_CLASS; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      cnt_value_q <= rd_val;
      for (int c = 0; c < NUM_CLASS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign cnt_value = cnt_value_q;

endmodule

// File: tb/tb_instr_class_tracker.sv
// Bench for instr_class_tracker: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_class_tracker;

  localparam int FW   = 4;
  localparam int NC   = 9;
  localparam int ST   = 3;
  localparam int CW   = 4;
  localparam int SW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic [FW-1:0]    in_func;
  logic             stall;
  logic             flush;
  logic [ST-1:0]    stage_valid;
  logic [ST*FW-1:0] stage_func;
  logic [NC-1:0]    inflight;
  logic             retire;
  logic [SW-1:0]    cnt_sel;
  logic             cnt_clr;
  logic [CW-1:0]    cnt_value;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instr_class_tracker #(
    .FUNC_W(FW), .NUM_CLASS(NC), .STAGES(ST), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_func(in_func),
    .stall(stall), .flush(flush),
    .stage_valid(stage_valid), .stage_func(stage_func),
    .inflight(inflight), .retire(retire),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr),
    .cnt_value(cnt_value)
  );

  typedef struct { bit v; int f; } ent_t;
  ent_t pipe[$];
  int   mcnt[NC];
  int   mval;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int k = 0; k < ST; k++) pipe.push_back('{1'b0, 0});
    for (int c = 0; c < NC; c++) mcnt[c] = 0;
    mval = 0;
  endtask

  task automatic model_edge();
    ent_t last = pipe[ST-1];
    ent_t e;
    mval = (int'(cnt_sel) < NC) ? mcnt[cnt_sel] : 0;
    if (cnt_clr) begin
      for (int c = 0; c < NC; c++) mcnt[c] = 0;
    end else if (last.v) begin
      mcnt[last.f] = (mcnt[last.f] >= CMAX) ? CMAX : mcnt[last.f] + 1;
    end
    e.v = in_valid && !stall && !flush;
    e.f = !e.v ? 0 : (int'(in_func) >= NC ? NC - 1 : int'(in_func));
    void'(pipe.pop_back());
    pipe.push_front(e);
    if (flush) for (int k = 1; k <= ST - 2; k++) pipe[k] = '{1'b0, 0};
  endtask

  task automatic check_model();
    logic [31:0] sv, sf, inf;
    sv = 0; sf = 0; inf = 0;
    for (int k = 0; k < ST; k++) begin
      sv[k] = pipe[k].v;
      sf = sf | (32'(pipe[k].f) << (k * FW));
      if (pipe[k].v) inf[pipe[k].f] = 1'b1;
    end
    chk("m.stage_valid", 32'(stage_valid), sv);
    chk("m.stage_func", 32'(stage_func), sf);
    chk("m.inflight", 32'(inflight), inf);
    chk("m.retire", 32'(retire), 32'(pipe[ST-1].v));
    chk("m.cnt_value", 32'(cnt_value), 32'(mval));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_func = 0; stall = 0; flush = 0;
    cnt_clr = 0; cnt_sel = 0;
  endtask

  typedef struct {
    bit iv; bit [3:0] fn; bit st; bit fl; bit [3:0] sel;
    bit [2:0] sv; bit [11:0] sf; bit [8:0] inf; bit ret; bit [3:0] cv;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(bit iv, int fn, bit st, bit fl, int sel,
                             int sv, int sf, int inf, bit ret, int cv);
    vec_t r;
    r.iv = iv; r.fn = 4'(fn); r.st = st; r.fl = fl; r.sel = 4'(sel);
    r.sv = 3'(sv); r.sf = 12'(sf); r.inf = 9'(inf); r.ret = ret;
    r.cv = 4'(cv);
    return r;
  endfunction

  initial begin
    idle_inputs();
    reset_n = 0;
    model_reset();

    // Reset held with a live instruction at the input
    in_valid = 1; in_func = 2;
    #2;
    repeat (3) begin
      step();
      chk("rst.stage_valid", 32'(stage_valid), 0);
      chk("rst.inflight", 32'(inflight), 0);
      chk("rst.cnt_value", 32'(cnt_value), 0);
    end
    reset_n = 1;
    step();
    chk("rst.first_valid", 32'(stage_valid), 32'h1);
    chk("rst.first_func", 32'(stage_func), 32'h2);

    idle_inputs();
    reset_n = 0;
    step();
    reset_n = 1;

    tbl.push_back(v(1,  0, 0, 0,  0, 'b001, 'h000, 'h001, 0, 0));
    tbl.push_back(v(1,  1, 0, 0,  0, 'b011, 'h001, 'h003, 0, 0));
    tbl.push_back(v(1,  2, 0, 0,  0, 'b111, 'h012, 'h007, 1, 0));
    tbl.push_back(v(0,  0, 0, 0,  0, 'b110, 'h120, 'h006, 1, 0));
    tbl.push_back(v(0,  0, 0, 0,  0, 'b100, 'h200, 'h004, 1, 1));
    tbl.push_back(v(0,  0, 0, 0,  1, 'b000, 'h000, 'h000, 0, 1));
    tbl.push_back(v(0,  0, 0, 0,  2, 'b000, 'h000, 'h000, 0, 1));
    tbl.push_back(v(1,  4, 1, 0,  4, 'b000, 'h000, 'h000, 0, 0));
    tbl.push_back(v(1,  4, 1, 0,  4, 'b000, 'h000, 'h000, 0, 0));
    tbl.push_back(v(1,  4, 0, 0,  4, 'b001, 'h004, 'h010, 0, 0));
    tbl.push_back(v(0,  0, 0, 0,  4, 'b010, 'h040, 'h010, 0, 0));
    tbl.push_back(v(0,  0, 0, 0,  4, 'b100, 'h400, 'h010, 1, 0));
    tbl.push_back(v(0,  0, 0, 0,  4, 'b000, 'h000, 'h000, 0, 0));
    tbl.push_back(v(0,  0, 0, 0,  4, 'b000, 'h000, 'h000, 0, 1));
    tbl.push_back(v(1,  5, 0, 0,  5, 'b001, 'h005, 'h020, 0, 0));
    tbl.push_back(v(1,  6, 0, 0,  5, 'b011, 'h056, 'h060, 0, 0));
    tbl.push_back(v(1,  7, 0, 0,  5, 'b111, 'h567, 'h0E0, 1, 0));
    tbl.push_back(v(1,  3, 0, 1,  5, 'b100, 'h600, 'h040, 1, 0));
    tbl.push_back(v(0,  0, 0, 0,  5, 'b000, 'h000, 'h000, 0, 1));
    tbl.push_back(v(0,  0, 0, 0,  7, 'b000, 'h000, 'h000, 0, 0));
    tbl.push_back(v(0,  0, 0, 0,  6, 'b000, 'h000, 'h000, 0, 1));
    tbl.push_back(v(1, 12, 0, 0, 10, 'b001, 'h008, 'h100, 0, 0));
    tbl.push_back(v(0,  0, 0, 0, 10, 'b010, 'h080, 'h100, 0, 0));
    tbl.push_back(v(0,  0, 0, 0, 10, 'b100, 'h800, 'h100, 1, 0));
    tbl.push_back(v(0,  0, 0, 0,  8, 'b000, 'h000, 'h000, 0, 0));
    tbl.push_back(v(0,  0, 0, 0,  8, 'b000, 'h000, 'h000, 0, 1));
    tbl.push_back(v(1,  3, 1, 1,  8, 'b000, 'h000, 'h000, 0, 1));

    foreach (tbl[i]) begin
      in_valid = tbl[i].iv; in_func = tbl[i].fn;
      stall = tbl[i].st; flush = tbl[i].fl;
      cnt_sel = tbl[i].sel; cnt_clr = 0;
      step();
      chk($sformatf("t%0d.valid", i), 32'(stage_valid), 32'(tbl[i].sv));
      chk($sformatf("t%0d.func", i), 32'(stage_func), 32'(tbl[i].sf));
      chk($sformatf("t%0d.inflight", i), 32'(inflight), 32'(tbl[i].inf));
      chk($sformatf("t%0d.retire", i), 32'(retire), 32'(tbl[i].ret));
      chk($sformatf("t%0d.cnt", i), 32'(cnt_value), 32'(tbl[i].cv));
    end

    // Saturation of CALC_R
    idle_inputs();
    in_valid = 1; in_func = 0;
    repeat (20) step();
    in_valid = 0;
    repeat (4) step();
    step();
    chk("sat.value", 32'(cnt_value), CMAX);

    // Clear coinciding with a retire
    in_valid = 1; in_func = 0;
    step();
    in_valid = 0;
    repeat (2) step();
    chk("clr.retire_pending", 32'(retire), 1);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr.pre_value", 32'(cnt_value), CMAX);
    step();
    chk("clr.read_zero", 32'(cnt_value), 0);
    step();
    chk("clr.not_counted", 32'(cnt_value), 0);

    // Randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_func  = 4'($urandom_range(0, 15));
      stall    = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      cnt_clr  = ($urandom_range(0, 59) == 0);
      cnt_sel  = 4'($urandom_range(0, 15));
      if (i == 300) begin
        #2 reset_n = 0;
        #1;
        chk("arst.valid", 32'(stage_valid), 0);
        chk("arst.func", 32'(stage_func), 0);
        chk("arst.inflight", 32'(inflight), 0);
        chk("arst.retire", 32'(retire), 0);
        chk("arst.cnt", 32'(cnt_value), 0);
        model_reset();
        step();
        reset_n = 1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
